// File: rtl/seq_multiplier_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Optional build macro: SEQ_MULTIPLIER_EARLY_TERM_EN (see seq_multiplier.sv).
package seq_multiplier_pkg;

  // Controller states: waiting for operands, iterating, holding a product.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Helpers work on a fixed wide container and are told the live width,
  // so one function serves both WIDTH-bit operands and 2*WIDTH-bit products.
  localparam int MAX_W = 128;
  typedef logic [MAX_W-1:0] wide_t;

  // Bits needed to hold a step counter that starts at iter and counts to 0.
  function automatic int cntWidth(input int iter);
    return $clog2(iter + 1);
  endfunction

  // Mask with the low w bits set.
  function automatic wide_t widthMask(input int w);
    wide_t m;
    m = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Magnitude of a w-bit value. The most-negative value maps to 2^(w-1),
  // which still fits in w unsigned bits.
  function automatic wide_t magnitude(input wide_t v, input int w, input logic isSigned);
    wide_t m;
    wide_t topBit;
    m      = widthMask(w);
    topBit = wide_t'(1) << (w - 1);
    if (isSigned && ((v & topBit) != '0)) return (~v + wide_t'(1)) & m;
    return v & m;
  endfunction

  // Two's-complement negate modulo 2^w when neg is set; zero stays zero.
  function automatic wide_t condNegate(input wide_t v, input int w, input logic neg);
    wide_t m;
    m = widthMask(w);
    if (neg) return (~v + wide_t'(1)) & m;
    return v & m;
  endfunction

endpackage

// File: rtl/seq_multiplier_step.sv
// One BUSY-cycle of the shift-add multiplier: adds |A| times a
// BITS_PER_CYCLE-bit slice of |B|, shifted into place, to the accumulator.
module seq_multiplier_step #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1,
  parameter int SHW            = 4
) (
  input  logic [2*WIDTH-1:0]        acc_i,
  input  logic [WIDTH-1:0]          mcand_i,
  input  logic [BITS_PER_CYCLE-1:0] slice_i,
  input  logic [SHW-1:0]            shamt_i,
  output logic [2*WIDTH-1:0]        acc_o
);

  logic [2*WIDTH-1:0] mcandExt;
  logic [2*WIDTH-1:0] sliceExt;
  logic [2*WIDTH-1:0] partial;

  // Partial product is at most WIDTH+BITS_PER_CYCLE bits, so 2*WIDTH never overflows.
  always_comb begin
    mcandExt = {{WIDTH{1'b0}}, mcand_i};
    sliceExt = {{(2*WIDTH-BITS_PER_CYCLE){1'b0}}, slice_i};
    partial  = mcandExt * sliceExt;
    acc_o    = acc_i + (partial << shamt_i);
  end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier returning the full 2*WIDTH-bit product,
// signed or unsigned per transaction, with valid/ready on both sides.
// Optional build macro: SEQ_MULTIPLIER_EARLY_TERM_EN - finish as soon as
// the remaining multiplier bits are all zero instead of after a fixed count.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out,
  output logic                 busy
);

  localparam int ITER = WIDTH / BITS_PER_CYCLE;
  localparam int CW   = cntWidth(ITER);
  localparam int SHW  = $clog2(2 * WIDTH);

  // Reject configurations the datapath cannot implement.
  if (WIDTH < 2 || (WIDTH % BITS_PER_CYCLE) != 0 || BITS_PER_CYCLE < 1 || 2 * WIDTH > MAX_W) begin : g_badParams
    $error("seq_multiplier: WIDTH must be >= 2 and <= 64 and divisible by BITS_PER_CYCLE");
  end

  state_e state_q, state_d;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               neg_q, neg_d;
  logic [CW-1:0]      count_q, count_d;
  logic [SHW-1:0]     shift_q, shift_d;
  logic [2*WIDTH-1:0] out_q, out_d;

  logic [2*WIDTH-1:0] accStep;
  logic [WIDTH-1:0]   remaining;
  logic               lastStep;
  logic               accept;
  wide_t              magA;
  wide_t              magB;
  wide_t              finalWide;

  seq_multiplier_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE),
    .SHW            (SHW)
  ) u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .slice_i (mplier_q[BITS_PER_CYCLE-1:0]),
    .shamt_i (shift_q),
    .acc_o   (accStep)
  );

  // Decide whether the current BUSY step is the final one.
  always_comb begin
    remaining = mplier_q >> BITS_PER_CYCLE;
    accept    = in_valid && (state_q == IDLE);
`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
    lastStep  = (count_q == CW'(1)) || (remaining == '0);
`else
    lastStep  = (count_q == CW'(1));
`endif
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!srst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: one transaction at a time, no overlap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (lastStep) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode directly from the state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == BUSY) || (state_q == DONE);
    out       = out_q;
  end

  // Datapath next values: load magnitudes on accept, step while busy, sign-fix at the end.
  always_comb begin
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    neg_d     = neg_q;
    count_d   = count_q;
    shift_d   = shift_q;
    out_d     = out_q;
    magA      = magnitude(wide_t'(A), WIDTH, in_signed);
    magB      = magnitude(wide_t'(B), WIDTH, in_signed);
    finalWide = condNegate(wide_t'(accStep), 2 * WIDTH, neg_q);
    if (accept) begin
      acc_d    = '0;
      mcand_d  = magA[WIDTH-1:0];
      mplier_d = magB[WIDTH-1:0];
      neg_d    = in_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
      count_d  = CW'(ITER);
      shift_d  = '0;
    end else if (state_q == BUSY) begin
      acc_d    = accStep;
      mplier_d = remaining;
      count_d  = count_q - CW'(1);
      shift_d  = shift_q + SHW'(BITS_PER_CYCLE);
      if (lastStep) out_d = finalWide[2*WIDTH-1:0];
    end
  end

  // Datapath registers; reset clears the product so an aborted operation leaves out=0.
  always_ff @(posedge clk) begin
    if (!srst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      count_q  <= '0;
      shift_q  <= '0;
      out_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      count_q  <= count_d;
      shift_q  <= shift_d;
      out_q    <= out_d;
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier at WIDTH=8, BITS_PER_CYCLE=1.
// Honours SEQ_MULTIPLIER_EARLY_TERM_EN when computing expected latency.
module tb_seq_multiplier;

  logic        clk;
  logic        srst;
  logic        in_valid;
  logic        in_ready;
  logic        in_signed;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        busy;

  int checks;
  int errors;
  logic [15:0] expQ[$];
  logic [15:0] expNow;
  int          lat;
  logic        flag;

  seq_multiplier #(
    .WIDTH          (8),
    .BITS_PER_CYCLE (1)
  ) dut (
    .clk       (clk),
    .srst      (srst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference product using plain 32-bit integer multiplication.
  function automatic logic [15:0] refProduct(input logic [7:0] a, input logic [7:0] b, input logic s);
    int pa;
    int pb;
    int p;
    if (s) begin
      pa = int'($signed(a));
      pb = int'($signed(b));
    end else begin
      pa = int'(a);
      pb = int'(b);
    end
    p = pa * pb;
    return p[15:0];
  endfunction

  // Cycles from acceptance to out_valid.
  function automatic int expLatency(input logic [7:0] b, input logic s);
`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
    int mag;
    int hi;
    mag = (s && b[7]) ? -int'($signed(b)) : int'(b);
    hi  = -1;
    for (int i = 0; i < 8; i++) if (mag[i]) hi = i;
    return (hi < 0) ? 1 : hi + 1;
`else
    return (b === 8'hxx) ? 0 : 8;
`endif
  endfunction

  // Present operands, wait for acceptance, push the expected product and time the latency.
  task automatic applyStimulus(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s);
    logic lowAll;
    in_valid  = 1'b1;
    A         = a;
    B         = b;
    in_signed = s;
    lat = 0;
    while (!in_ready && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_acceptReady"}, {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    A        = 8'h00;
    B        = 8'h00;
    expQ.push_back(refProduct(a, b, s));
    lat    = 0;
    lowAll = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready) lowAll = 1'b0;
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, expLatency(b, s));
    check({tag, "_inReadyLow"}, {31'd0, lowAll}, 32'd1);
  endtask

  // Compare the held product with the scoreboard, then complete the output handshake.
  task automatic checkOutput(input string tag);
    expNow = (expQ.size() > 0) ? expQ.pop_front() : 16'hxxxx;
    check({tag, "_outValid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_product"}, {16'd0, out}, {16'd0, expNow});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_validDrop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_readyBack"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rs;
    checks    = 0;
    errors    = 0;
    srst      = 1'b0;
    in_valid  = 1'b0;
    in_signed = 1'b0;
    A         = 8'h00;
    B         = 8'h00;
    out_ready = 1'b0;
    $display("[TB] starting seq_multiplier bench");

    tick();
    tick();
    check("reset_inReady", {31'd0, in_ready}, 32'd1);
    check("reset_outValid", {31'd0, out_valid}, 32'd0);
    check("reset_out", {16'd0, out}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    srst = 1'b1;
    tick();

    applyStimulus("u255x255", 8'hFF, 8'hFF, 1'b0);
    check("u255x255_busy", {31'd0, busy}, 32'd1);
    checkOutput("u255x255");

    applyStimulus("sMinxMin", 8'h80, 8'h80, 1'b1);
    checkOutput("sMinxMin");
    applyStimulus("sM3x5", 8'hFD, 8'h05, 1'b1);
    checkOutput("sM3x5");
    applyStimulus("uFDx05", 8'hFD, 8'h05, 1'b0);
    checkOutput("uFDx05");
    applyStimulus("s0xM1", 8'h00, 8'hFF, 1'b1);
    checkOutput("s0xM1");

    // Back-pressure: product must hold while out_ready stays low.
    applyStimulus("hold", 8'h07, 8'hF7, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_out", {16'd0, out}, {16'd0, expQ[0]});
      check("hold_outValid", {31'd0, out_valid}, 32'd1);
      check("hold_inReady", {31'd0, in_ready}, 32'd0);
    end
    checkOutput("hold");
    check("hold_outKept", {16'd0, out}, {16'd0, expNow});

    // Reset on BUSY cycle 4 aborts without emitting a product.
    in_valid  = 1'b1;
    A         = 8'h55;
    B         = 8'h99;
    in_signed = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    srst = 1'b0;
    tick();
    srst = 1'b1;
    check("abort_inReady", {31'd0, in_ready}, 32'd1);
    check("abort_outValid", {31'd0, out_valid}, 32'd0);
    check("abort_out", {16'd0, out}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    flag = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) flag = 1'b1;
    end
    check("abort_noProduct", {31'd0, flag}, 32'd0);

    applyStimulus("bZero", 8'h5A, 8'h00, 1'b0);
    checkOutput("bZero");
    applyStimulus("bThree", 8'h5A, 8'h03, 1'b0);
    checkOutput("bThree");
    applyStimulus("sBm3", 8'h11, 8'hFD, 1'b1);
    checkOutput("sBm3");

    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      applyStimulus("rand", ra, rb, rs);
      checkOutput("rand");
    end

    check("scoreboard_empty", expQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
